bench_sequencer: RTL and testbench

Run controller for FPGA benchmarking: on a debounced button press it clears the display timer, launches the design under test (DUT) twice, once per implementation channel, and frames each run with the matching timer enable. It drives the timer's clear and `t1_ena`/`t2_ena` inputs, giving the timer's run windows a producer. It sits between the board button, the DUT start/done handshake and the seven-segment timer. It also latches exact per-run cycle counts for ILA readout.

---
 rtl/bench_pkg.sv | 48 ++++
 rtl/button_debounce.sv | 55 +++++
 rtl/bench_sequencer.sv | 137 +++++++++++++
 tb/tb_bench_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bench_pkg.sv
// Shared types and defaults for the benchmark run controller: FSM states,
// cycle count type, 100 MHz timing constants and the per-state output decode.
package bench_pkg;

  typedef logic [31:0] cycle_t;

  localparam int DEF_DEBOUNCE_CYCLES = 1_000_000;      // 10 ms at 100 MHz
  localparam int DEF_TIMEOUT_CYCLES  = 1_000_000_000;  // 10 s, timer display limit

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR,
    ST_S1,
    ST_W1,
    ST_GAP,
    ST_S2,
    ST_W2,
    ST_FIN,
    ST_ERR
  } state_t;

  typedef struct packed {
    logic timer_clr;
    logic dut_start;
    logic dut_sel;
    logic t1_ena;
    logic t2_ena;
    logic busy;
    logic done_led;
    logic err_led;
  } ctl_t;

  // Moore decode: every control output is a pure function of the state.
  function automatic ctl_t state_ctl(state_t s);
    ctl_t c;
    c           = '0;
    c.timer_clr = (s == ST_CLR);
    c.dut_start = (s == ST_S1) || (s == ST_S2);
    c.dut_sel   = (s == ST_S2) || (s == ST_W2);
    c.t1_ena    = (s == ST_S1) || (s == ST_W1);
    c.t2_ena    = (s == ST_S2) || (s == ST_W2);
    c.busy      = (s != ST_IDLE) && (s != ST_FIN) && (s != ST_ERR);
    c.done_led  = (s == ST_FIN);
    c.err_led   = (s == ST_ERR);
    return c;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Board button conditioner: 2-flop synchroniser, stability counter and a
// registered level; valid_o rises once the first level has been accepted.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic valid_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             cand_q;
  logic             level_q, valid_q;
  logic [CNT_W-1:0] cnt_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, exactly like the hardware.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cand_q  <= 1'b0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        // Any bounce restarts the stability window on the new candidate.
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (!valid_q || (cand_q != level_q)) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= cand_q;
          valid_q <= 1'b1;
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign level_o = level_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/bench_sequencer.sv
// Benchmark run controller: on a debounced press, clears the timer and runs the
// DUT once per channel, framing each run with its timer enable and count.
module bench_sequencer
  import bench_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic        CLK100MHZ,
  input  logic        btn_reset_n,
  input  logic        btn_start,
  input  logic        dut_done,
  output logic        dut_start,
  output logic        dut_sel,
  output logic        timer_clr,
  output logic        t1_ena,
  output logic        t2_ena,
  output logic        busy,
  output logic        done_led,
  output logic        err_led,
  output logic        err_chan,
  output logic [31:0] cyc1,
  output logic [31:0] cyc2
);

  localparam cycle_t TIMEOUT_LAST = cycle_t'(TIMEOUT_CYCLES - 1);

  state_t state_q, state_d;
  ctl_t   ctl_q, ctl_d;
  cycle_t run_cnt_q, run_cnt_d;
  cycle_t cyc1_q, cyc1_d;
  cycle_t cyc2_q, cyc2_d;
  logic   err_chan_q, err_chan_d;
  logic   level_prev_q, prev_valid_q;
  logic   btn_level, btn_valid;
  logic   start_evt;
  logic   timeout_hit;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_debounce (
    .clk    (CLK100MHZ),
    .rst_n  (btn_reset_n),
    .btn_i  (btn_start),
    .level_o(btn_level),
    .valid_o(btn_valid)
  );

  // The edge detector arms one cycle after the first accepted level, so a
  // button held through reset settles as "pressed" without firing.
  assign start_evt   = btn_valid && prev_valid_q && btn_level && !level_prev_q;
  assign timeout_hit = (run_cnt_q == TIMEOUT_LAST);

  // NOTE: every signal assigned here gets a default first, so no path through
  // the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    cyc1_d     = cyc1_q;
    cyc2_d     = cyc2_q;
    err_chan_d = err_chan_q;

    unique case (state_q)
      ST_IDLE, ST_FIN, ST_ERR: if (start_evt) state_d = ST_CLR;
      ST_CLR:                  state_d = ST_S1;
      ST_S1:                   state_d = ST_W1;
      ST_W1: begin
        if (dut_done) begin
          state_d = ST_GAP;
          cyc1_d  = run_cnt_q + cycle_t'(1);
        end else if (timeout_hit) begin
          state_d    = ST_ERR;
          err_chan_d = 1'b0;
        end
      end
      ST_GAP:                  if (!dut_done) state_d = ST_S2;
      ST_S2:                   state_d = ST_W2;
      ST_W2: begin
        if (dut_done) begin
          state_d = ST_FIN;
          cyc2_d  = run_cnt_q + cycle_t'(1);
        end else if (timeout_hit) begin
          state_d    = ST_ERR;
          err_chan_d = 1'b1;
        end
      end
      default:                 state_d = ST_IDLE;
    endcase

    if (ctl_q.t1_ena || ctl_q.t2_ena) run_cnt_d = run_cnt_q + cycle_t'(1);
    if (state_d == ST_S2 && state_q != ST_S2) run_cnt_d = '0;
    if (state_d == ST_CLR) begin
      run_cnt_d  = '0;
      cyc1_d     = '0;
      cyc2_d     = '0;
      err_chan_d = 1'b0;
    end

    // Outputs are decoded from the next state and registered with it.
    ctl_d = state_ctl(state_d);
  end

  always_ff @(posedge CLK100MHZ or negedge btn_reset_n) begin
    if (!btn_reset_n) begin
      state_q      <= ST_IDLE;
      ctl_q        <= '0;
      run_cnt_q    <= '0;
      cyc1_q       <= '0;
      cyc2_q       <= '0;
      err_chan_q   <= 1'b0;
      level_prev_q <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      ctl_q        <= ctl_d;
      run_cnt_q    <= run_cnt_d;
      cyc1_q       <= cyc1_d;
      cyc2_q       <= cyc2_d;
      err_chan_q   <= err_chan_d;
      level_prev_q <= btn_level;
      prev_valid_q <= btn_valid;
    end
  end

  assign timer_clr = ctl_q.timer_clr;
  assign dut_start = ctl_q.dut_start;
  assign dut_sel   = ctl_q.dut_sel;
  assign t1_ena    = ctl_q.t1_ena;
  assign t2_ena    = ctl_q.t2_ena;
  assign busy      = ctl_q.busy;
  assign done_led  = ctl_q.done_led;
  assign err_led   = ctl_q.err_led;
  assign err_chan  = err_chan_q;
  assign cyc1      = cyc1_q;
  assign cyc2      = cyc2_q;

endmodule

// File: tb/tb_bench_sequencer.sv
// Randomised scoreboard bench for bench_sequencer: a behavioural DUT responder,
// a per-sequence reference model and an output monitor that scores each run.
module tb_bench_sequencer;

  localparam int DEB   = 4;
  localparam int TOUT  = 50;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        btn_start = 1'b0;
  logic        dut_done = 1'b0;
  logic        dut_start, dut_sel, timer_clr, t1_ena, t2_ena;
  logic        busy, done_led, err_led, err_chan;
  logic [31:0] cyc1, cyc2;

  bench_sequencer #(
    .DEBOUNCE_CYCLES(DEB),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .CLK100MHZ  (clk),
    .btn_reset_n(rst_n),
    .btn_start  (btn_start),
    .dut_done   (dut_done),
    .dut_start  (dut_start),
    .dut_sel    (dut_sel),
    .timer_clr  (timer_clr),
    .t1_ena     (t1_ena),
    .t2_ena     (t2_ena),
    .busy       (busy),
    .done_led   (done_led),
    .err_led    (err_led),
    .err_chan   (err_chan),
    .cyc1       (cyc1),
    .cyc2       (cyc2)
  );

  always #5 clk = ~clk;

  typedef struct {
    int clr, starts, clr_to_start, w1, w2, gap, overlap, sel_bad, stale;
    int done, err, chan, cyc1, cyc2;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0, errors = 0;
  int   cfg_n[2], cfg_h[2];
  int   cyc_cnt = 0, n_done = 0, exp_seqs = 0;
  int   total_clr = 0, total_starts = 0, exp_clr = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: a run whose done arrives N cycles after its start lasts N+1
  // enabled cycles unless that exceeds the timeout window.
  function automatic rec_t model(input int n1, input int h1, input int n2);
    rec_t e = '{default: 0};
    e.clr = 1;
    e.clr_to_start = 1;
    if (n1 >= TOUT) begin
      e.starts = 1; e.w1 = TOUT; e.err = 1; e.chan = 0;
    end else begin
      e.starts = 2; e.w1 = n1 + 1; e.cyc1 = n1 + 1; e.gap = h1;
      if (n2 >= TOUT) begin
        e.w2 = TOUT; e.err = 1; e.chan = 1;
      end else begin
        e.w2 = n2 + 1; e.cyc2 = n2 + 1; e.done = 1;
      end
    end
    return e;
  endfunction

  always @(posedge clk) cyc_cnt++;

  // Behavioural DUT: raises done cfg_n cycles after its start, holds cfg_h cycles.
  int wait_left = 0, hold_left = 0;
  int sel_l = 0;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_left = 0; hold_left = 0; dut_done = 1'b0;
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) dut_done = 1'b0;
      end
      if (dut_start) begin
        sel_l = dut_sel ? 1 : 0;
        wait_left = cfg_n[sel_l];
      end else if (wait_left > 0) begin
        wait_left--;
        if (wait_left == 0) begin
          dut_done = 1'b1;
          hold_left = cfg_h[sel_l];
        end
      end
    end
  end

  // Monitor: accumulates one record per busy period and scores it on busy fall.
  rec_t act_r;
  bit   in_seq = 0, busy_prev = 0;
  int   clr_cyc = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_seq = 0; busy_prev = 0;
    end else begin
      if (timer_clr) total_clr++;
      if (dut_start) total_starts++;
      if (busy && !busy_prev) begin
        act_r = '{default: 0};
        in_seq = 1;
      end
      if (in_seq && busy) begin
        if (timer_clr) begin
          act_r.clr++;
          clr_cyc = cyc_cnt;
          if (done_led || err_led || err_chan || cyc1 != 0 || cyc2 != 0) act_r.stale++;
        end
        if (dut_start) begin
          if (act_r.starts == 0) act_r.clr_to_start = cyc_cnt - clr_cyc;
          act_r.starts++;
        end
        if (t1_ena) act_r.w1++;
        if (t2_ena) act_r.w2++;
        if ((t1_ena && t2_ena) || (timer_clr && t1_ena)) act_r.overlap++;
        if ((t1_ena && dut_sel) || (t2_ena && !dut_sel)) act_r.sel_bad++;
        if (!t1_ena && !t2_ena && act_r.w1 > 0 && act_r.w2 == 0) act_r.gap++;
      end
      if (in_seq && !busy && busy_prev) begin
        rec_t e;
        act_r.done = done_led; act_r.err = err_led; act_r.chan = err_chan;
        act_r.cyc1 = cyc1; act_r.cyc2 = cyc2;
        check("expected_available", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("clr_pulses", act_r.clr, e.clr);
          check("dut_starts", act_r.starts, e.starts);
          check("clr_to_start", act_r.clr_to_start, e.clr_to_start);
          check("t1_window", act_r.w1, e.w1);
          check("t2_window", act_r.w2, e.w2);
          check("gap_cycles", act_r.gap, e.gap);
          check("enable_overlap", act_r.overlap, e.overlap);
          check("sel_mismatch", act_r.sel_bad, e.sel_bad);
          check("stale_in_clr", act_r.stale, e.stale);
          check("done_led", act_r.done, e.done);
          check("err_led", act_r.err, e.err);
          if (e.err != 0) check("err_chan", act_r.chan, e.chan);
          check("cyc1", act_r.cyc1, e.cyc1);
          check("cyc2", act_r.cyc2, e.cyc2);
        end
        n_done++;
        in_seq = 0;
      end
      busy_prev = busy;
    end
  end

  task automatic press(input bit bounce);
    if (bounce) begin
      for (int i = 0; i < 10; i++) begin
        btn_start = (i % 2 == 0);
        repeat (2) @(negedge clk);
      end
    end
    btn_start = 1'b1;
    repeat (12) @(negedge clk);
    btn_start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic wait_seq(input int target);
    int n = 0;
    while (n_done < target && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("sequence_complete", n_done, target);
    repeat (30) @(negedge clk);
  endtask

  task automatic run_seq(input int n1, input int h1, input int n2, input int h2,
                         input bit bounce, input bit double_press);
    cfg_n[0] = n1; cfg_h[0] = h1; cfg_n[1] = n2; cfg_h[1] = h2;
    exp_q.push_back(model(n1, h1, n2));
    exp_seqs++;
    exp_clr++;
    press(bounce);
    if (double_press) press(1'b0);
    wait_seq(exp_seqs);
  endtask

  initial begin
    int starts_before, seqs_before;
    repeat (3) @(negedge clk);
    check("reset_ctl", {dut_start, dut_sel, timer_clr, t1_ena, t2_ena, busy,
                        done_led, err_led, err_chan}, 0);
    check("reset_cyc1", cyc1, 0);
    check("reset_cyc2", cyc2, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    run_seq(10, 1, 10, 1, 1'b0, 1'b0);     // clean press
    run_seq(10, 1, 10, 1, 1'b1, 1'b0);     // bouncing press
    run_seq(12, 2, NEVER, 1, 1'b0, 1'b0);  // channel 2 never completes
    run_seq(10, 5, 10, 1, 1'b0, 1'b0);     // done held through the gap
    run_seq(45, 1, 10, 1, 1'b0, 1'b1);     // second press while busy
    run_seq(TOUT - 1, 1, TOUT - 1, 1, 1'b0, 1'b0);  // done on the last cycle
    run_seq(TOUT, 1, 10, 1, 1'b0, 1'b0);   // channel 1 times out
    run_seq(3, 1, 7, 2, 1'b0, 1'b0);       // press from ERR
    for (int i = 0; i < 8; i++)
      run_seq($urandom_range(1, 55), $urandom_range(1, 6),
              $urandom_range(1, 55), $urandom_range(1, 3), 1'b0, 1'b0);

    // Reset in the middle of a channel-1 run.
    cfg_n[0] = 40; cfg_h[0] = 1; cfg_n[1] = 10; cfg_h[1] = 1;
    exp_clr++;
    press(1'b0);
    check("pre_reset_t1_ena", t1_ena, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_ctl", {dut_start, dut_sel, timer_clr, t1_ena, t2_ena, busy,
                              done_led, err_led, err_chan}, 0);
    check("async_reset_cyc1", cyc1, 0);
    check("async_reset_cyc2", cyc2, 0);
    starts_before = total_starts;
    seqs_before = n_done;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("no_start_after_reset", total_starts, starts_before);
    check("idle_after_reset", busy, 0);
    check("no_record_after_reset", n_done, seqs_before);

    check("scoreboard_empty", exp_q.size(), 0);
    check("total_timer_clr", total_clr, exp_clr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
